// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS32 core, with load-use hazard detection.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_COUNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        id_RegDst,
    input  logic [1:0]        id_MemtoReg,
    input  logic [1:0]        id_ALUOp,
    input  logic              id_Jump,
    input  logic              id_Branch,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_ALUSrc,
    input  logic              id_RegWrite,
    input  logic              id_sign_or_zero,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_out,
    output logic              ex_valid,
    output logic [1:0]        ex_RegDst,
    output logic [1:0]        ex_MemtoReg,
    output logic [1:0]        ex_ALUOp,
    output logic              ex_Jump,
    output logic              ex_Branch,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_ALUSrc,
    output logic              ex_RegWrite,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_wreg,
    output logic [31:0]       bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        RegDst;
        logic [1:0]        MemtoReg;
        logic [1:0]        ALUOp;
        logic              Jump;
        logic              Branch;
        logic              MemRead;
        logic              MemWrite;
        logic              ALUSrc;
        logic              RegWrite;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] wreg;
    } ex_t;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm, input logic sgn);
        logic signed [15:0] simm;
        simm = imm;
        if (sgn)
            ext_imm = DATA_W'(simm);
        else
            ext_imm = DATA_W'(imm);
    endfunction

    function automatic logic [REG_AW-1:0] sel_wreg(input logic [1:0] dst,
                                                   input logic [REG_AW-1:0] rt,
                                                   input logic [REG_AW-1:0] rd);
        case (dst)
            2'b00:   sel_wreg = rt;
            2'b01:   sel_wreg = rd;
            2'b10:   sel_wreg = REG_AW'(31);
            default: sel_wreg = '0;
        endcase
    endfunction

    ex_t               id_p0;
    ex_t               ex_p1;
    logic              load_use;
    logic [REG_AW-1:0] wreg_p0;

    // rs is always treated as a source; rt only when it is a register operand or store data
    always_comb begin
        load_use = ex_p1.valid & ex_p1.MemRead & id_valid & (ex_p1.rt != '0) &
                   ((ex_p1.rt == id_rs) |
                    ((ex_p1.rt == id_rt) & (~id_ALUSrc | id_MemWrite)));
    end

    assign stall_out = (load_use & ~flush) | ex_hold;

    // ---- stage p0: decode bundle assembled from the ID inputs ----
    always_comb begin
        id_p0         = '0;
        wreg_p0       = sel_wreg(id_RegDst, id_rt, id_rd);
        id_p0.pc4     = id_pc4;
        id_p0.rs_data = id_rs_data;
        id_p0.rt_data = id_rt_data;
        id_p0.imm     = ext_imm(id_imm, id_sign_or_zero);
        id_p0.rs      = id_rs;
        id_p0.rt      = id_rt;
        id_p0.wreg    = wreg_p0;
        if (id_valid) begin
            id_p0.valid    = 1'b1;
            id_p0.RegDst   = id_RegDst;
            id_p0.MemtoReg = id_MemtoReg;
            id_p0.ALUOp    = id_ALUOp;
            id_p0.Jump     = id_Jump;
            id_p0.Branch   = id_Branch;
            id_p0.MemRead  = id_MemRead;
            id_p0.MemWrite = id_MemWrite;
            id_p0.ALUSrc   = id_ALUSrc;
            id_p0.RegWrite = id_RegWrite & (id_RegDst != 2'b11) & (wreg_p0 != '0);
        end
    end

    // ---- stage p1: EX register; a bubble is the all-zero bundle ----
    always_ff @(posedge clk) begin
        if (reset)
            ex_p1 <= '0;
        else if (flush)
            ex_p1 <= '0;
        else if (!ex_hold)
            ex_p1 <= load_use ? '0 : id_p0;
    end

    assign ex_valid    = ex_p1.valid;
    assign ex_RegDst   = ex_p1.RegDst;
    assign ex_MemtoReg = ex_p1.MemtoReg;
    assign ex_ALUOp    = ex_p1.ALUOp;
    assign ex_Jump     = ex_p1.Jump;
    assign ex_Branch   = ex_p1.Branch;
    assign ex_MemRead  = ex_p1.MemRead;
    assign ex_MemWrite = ex_p1.MemWrite;
    assign ex_ALUSrc   = ex_p1.ALUSrc;
    assign ex_RegWrite = ex_p1.RegWrite;
    assign ex_pc4      = ex_p1.pc4;
    assign ex_rs_data  = ex_p1.rs_data;
    assign ex_rt_data  = ex_p1.rt_data;
    assign ex_imm      = ex_p1.imm;
    assign ex_rs       = ex_p1.rs;
    assign ex_rt       = ex_p1.rt;
    assign ex_wreg     = ex_p1.wreg;

`ifdef ID_EX_BUBBLE_COUNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        sat_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    logic [31:0] bcnt_p1;

    // only bubbles that the hazard itself inserts are counted
    always_ff @(posedge clk) begin
        if (reset)
            bcnt_p1 <= 32'd0;
        else if (!flush && !ex_hold && load_use)
            bcnt_p1 <= sat_inc(bcnt_p1);
    end

    assign bubble_cnt = bcnt_p1;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed MIPS sequences plus randomized traffic.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, flush, ex_hold;
    logic [1:0]  id_RegDst, id_MemtoReg, id_ALUOp;
    logic        id_Jump, id_Branch, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite, id_sign_or_zero;
    logic [31:0] id_pc4, id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall_out, ex_valid;
    logic [1:0]  ex_RegDst, ex_MemtoReg, ex_ALUOp;
    logic        ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_wreg;
    logic [31:0] bubble_cnt;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_RegDst(id_RegDst), .id_MemtoReg(id_MemtoReg), .id_ALUOp(id_ALUOp),
        .id_Jump(id_Jump), .id_Branch(id_Branch), .id_MemRead(id_MemRead),
        .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
        .id_sign_or_zero(id_sign_or_zero), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out), .ex_valid(ex_valid),
        .ex_RegDst(ex_RegDst), .ex_MemtoReg(ex_MemtoReg), .ex_ALUOp(ex_ALUOp),
        .ex_Jump(ex_Jump), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        reset, flush, hold, valid;
        bit [1:0]  RegDst, MemtoReg, ALUOp;
        bit        Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, sz;
        bit [31:0] pc4, rsd, rtd;
        bit [15:0] imm;
        bit [4:0]  rs, rt, rd;
    } stim_t;

    typedef struct {
        int        due;
        bit        dchk;
        bit        valid;
        bit [1:0]  RegDst, MemtoReg, ALUOp;
        bit        Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
        bit [31:0] pc4, rsd, rtd, imm;
        bit [4:0]  rs, rt, wreg;
        bit [31:0] bcnt;
    } exs_t;

    typedef struct {
        int due;
        bit stall;
    } stl_t;

    exs_t xq[$];
    stl_t sq[$];
    exs_t m;
    int   pcyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, pcyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic exs_t zst(input bit [31:0] bc);
        exs_t z;
        z = '{default: 0};
        z.dchk = 1'b1;
        z.bcnt = bc;
        return z;
    endfunction

    function automatic bit [31:0] bc_inc(input bit [31:0] c);
`ifdef ID_EX_BUBBLE_COUNT_EN
        return (c == 32'hFFFF_FFFF) ? c : c + 1;
`else
        return c;
`endif
    endfunction

    task automatic apply(input stim_t s);
        reset = s.reset; flush = s.flush; ex_hold = s.hold; id_valid = s.valid;
        id_RegDst = s.RegDst; id_MemtoReg = s.MemtoReg; id_ALUOp = s.ALUOp;
        id_Jump = s.Jump; id_Branch = s.Branch; id_MemRead = s.MemRead;
        id_MemWrite = s.MemWrite; id_ALUSrc = s.ALUSrc; id_RegWrite = s.RegWrite;
        id_sign_or_zero = s.sz; id_pc4 = s.pc4; id_rs_data = s.rsd; id_rt_data = s.rtd;
        id_imm = s.imm; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    endtask

    task automatic step(input stim_t s, output bit stall);
        bit   lu;
        exs_t n;
        @(posedge clk);
        #1;
        apply(s);
        lu = m.valid && m.MemRead && s.valid && (m.rt != 0) &&
             ((m.rt == s.rs) || ((m.rt == s.rt) && (!s.ALUSrc || s.MemWrite)));
        stall = (lu && !s.flush) || s.hold;
        sq.push_back('{due: pcyc, stall: stall});
        if (s.reset)      n = zst(0);
        else if (s.flush) n = zst(m.bcnt);
        else if (s.hold)  n = m;
        else if (lu)      n = zst(bc_inc(m.bcnt));
        else begin
            n      = zst(m.bcnt);
            n.dchk = s.valid;
            n.pc4  = s.pc4;
            n.rsd  = s.rsd;
            n.rtd  = s.rtd;
            n.rs   = s.rs;
            n.rt   = s.rt;
            n.imm  = 32'(s.imm) - ((s.sz && s.imm >= 16'h8000) ? 32'h0001_0000 : 32'h0);
            case (s.RegDst)
                2'd0: n.wreg = s.rt;
                2'd1: n.wreg = s.rd;
                2'd2: n.wreg = 5'd31;
                default: n.wreg = 5'd0;
            endcase
            if (s.valid) begin
                n.valid = 1; n.RegDst = s.RegDst; n.MemtoReg = s.MemtoReg; n.ALUOp = s.ALUOp;
                n.Jump = s.Jump; n.Branch = s.Branch; n.MemRead = s.MemRead;
                n.MemWrite = s.MemWrite; n.ALUSrc = s.ALUSrc;
                n.RegWrite = s.RegWrite && (n.wreg != 0);
            end
        end
        n.due = pcyc + 1;
        xq.push_back(n);
        m = n;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        stl_t es;
        exs_t e;
        while (sq.size() > 0 && sq[0].due <= pcyc) begin
            es = sq.pop_front();
            chk("stall_out", 32'(stall_out), 32'(es.stall));
        end
        while (xq.size() > 0 && xq[0].due <= pcyc) begin
            e = xq.pop_front();
            chk("ex_valid",    32'(ex_valid),    32'(e.valid));
            chk("ex_RegDst",   32'(ex_RegDst),   32'(e.RegDst));
            chk("ex_MemtoReg", 32'(ex_MemtoReg), 32'(e.MemtoReg));
            chk("ex_ALUOp",    32'(ex_ALUOp),    32'(e.ALUOp));
            chk("ex_Jump",     32'(ex_Jump),     32'(e.Jump));
            chk("ex_Branch",   32'(ex_Branch),   32'(e.Branch));
            chk("ex_MemRead",  32'(ex_MemRead),  32'(e.MemRead));
            chk("ex_MemWrite", 32'(ex_MemWrite), 32'(e.MemWrite));
            chk("ex_ALUSrc",   32'(ex_ALUSrc),   32'(e.ALUSrc));
            chk("ex_RegWrite", 32'(ex_RegWrite), 32'(e.RegWrite));
            chk("bubble_cnt",  bubble_cnt,       e.bcnt);
            if (e.dchk) begin
                chk("ex_pc4",     ex_pc4,          e.pc4);
                chk("ex_rs_data", ex_rs_data,      e.rsd);
                chk("ex_rt_data", ex_rt_data,      e.rtd);
                chk("ex_imm",     ex_imm,          e.imm);
                chk("ex_rs",      32'(ex_rs),      32'(e.rs));
                chk("ex_rt",      32'(ex_rt),      32'(e.rt));
                chk("ex_wreg",    32'(ex_wreg),    32'(e.wreg));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic stim_t base(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        stim_t s;
        s = '{default: 0};
        s.valid = 1; s.rs = rs; s.rt = rt; s.rd = rd;
        s.pc4 = $urandom; s.rsd = $urandom; s.rtd = $urandom; s.imm = 16'($urandom);
        return s;
    endfunction

    function automatic stim_t rtype(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        stim_t s;
        s = base(rs, rt, rd);
        s.RegDst = 2'b01; s.ALUOp = 2'b10; s.RegWrite = 1;
        return s;
    endfunction

    function automatic stim_t lw(input bit [4:0] rt, input bit [4:0] rs);
        stim_t s;
        s = base(rs, rt, 5'($urandom));
        s.MemRead = 1; s.MemtoReg = 2'b01; s.ALUSrc = 1; s.RegWrite = 1; s.sz = 1;
        return s;
    endfunction

    function automatic stim_t addi(input bit [4:0] rt, input bit [4:0] rs, input bit [15:0] imm, input bit sz);
        stim_t s;
        s = base(rs, rt, 5'($urandom));
        s.ALUSrc = 1; s.RegWrite = 1; s.imm = imm; s.sz = sz;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = base(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        s.valid = ($urandom_range(0, 9) != 0);
        s.RegDst = 2'($urandom); s.MemtoReg = 2'($urandom); s.ALUOp = 2'($urandom);
        s.Jump = 1'($urandom); s.Branch = 1'($urandom); s.MemRead = ($urandom_range(0, 2) == 0);
        s.MemWrite = 1'($urandom); s.ALUSrc = 1'($urandom); s.RegWrite = 1'($urandom);
        s.sz = 1'($urandom);
        s.flush = ($urandom_range(0, 9) == 0);
        s.hold = ($urandom_range(0, 9) == 0);
        s.reset = ($urandom_range(0, 49) == 0);
        return s;
    endfunction

    task automatic issue(input stim_t s);
        bit st;
        int n;
        n = 0;
        do begin
            step(s, st);
            n++;
        end while (st && n < 8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d expected completion", pcyc);
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        stim_t cur;
        bit    st;

        s = rnd_stim();
        s.reset = 1; s.flush = 0; s.hold = 0;
        apply(s);
        m = zst(0);
        m.due = 1;
        xq.push_back(m);

        repeat (2) begin
            s = rnd_stim();
            s.reset = 1; s.flush = 0; s.hold = 0;
            step(s, st);
        end

        issue(rtype(5'd1, 5'd2, 5'd3));
        issue(lw(5'd5, 5'd1));
        issue(rtype(5'd5, 5'd2, 5'd6));
        issue(lw(5'd0, 5'd1));
        issue(rtype(5'd0, 5'd2, 5'd6));
        issue(lw(5'd5, 5'd1));
        issue(addi(5'd7, 5'd5, 16'h0010, 1'b1));
        issue(lw(5'd5, 5'd1));
        issue(addi(5'd5, 5'd1, 16'h0004, 1'b1));
        issue(addi(5'd8, 5'd1, 16'h8000, 1'b1));
        issue(addi(5'd8, 5'd1, 16'h8000, 1'b0));
        s = base(5'd0, 5'd0, 5'd0);
        s.RegDst = 2'b10; s.RegWrite = 1; s.Jump = 1;
        issue(s);

        issue(lw(5'd5, 5'd1));
        s = rtype(5'd5, 5'd2, 5'd6);
        s.flush = 1; s.hold = 1;
        step(s, st);
        s.flush = 0; s.hold = 0;
        issue(s);

        issue(rtype(5'd1, 5'd2, 5'd3));
        s = rtype(5'd4, 5'd4, 5'd4);
        s.hold = 1;
        repeat (3) step(s, st);
        s.hold = 0;
        issue(s);

        s = rtype(5'd1, 5'd2, 5'd9);
        s.RegDst = 2'b11;
        issue(s);
        s = rtype(5'd1, 5'd2, 5'd9);
        s.valid = 0;
        issue(s);

        issue(lw(5'd5, 5'd1));
        s = rtype(5'd5, 5'd2, 5'd6);
        s.reset = 1;
        step(s, st);
        s.reset = 0;
        issue(s);

        st = 0;
        cur = rnd_stim();
        repeat (600) begin
            if (!st) cur = rnd_stim();
            else begin
                cur.flush = ($urandom_range(0, 9) == 0);
                cur.hold = ($urandom_range(0, 9) == 0);
                cur.reset = ($urandom_range(0, 49) == 0);
            end
            step(cur, st);
        end

        s = base(5'd0, 5'd0, 5'd0);
        s.valid = 0;
        step(s, st);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(sq.size() + xq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS32 core.
- Consumes the decode control bundle and the register-file read data.
- Latches them into EX-stage registers with immediate extension and destination-register selection.
- Contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble into EX.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- id_valid  in  1  the ID-stage instruction is real (not a bubble).
- id_RegDst, id_MemtoReg, id_ALUOp  in  2 each  decode control fields.
- id_Jump, id_Branch, id_MemRead, id_MemWrite, id_ALUSrc, id_RegWrite, id_sign_or_zero  in  1 each  decode control bits.
- id_pc4  in  DATA_W  PC+4 of the ID instruction.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  16  instruction[15:0].
- id_rs, id_rt, id_rd  in  REG_AW  register specifiers.
- flush  in  1  branch/jump redirect; kills the ID instruction.
- ex_hold  in  1  downstream stall; freezes this stage.
- stall_out  out  1  combinational; holds PC and IF/ID.
- ex_valid  out  1  the EX instruction is real.
- ex_RegDst, ex_MemtoReg, ex_ALUOp  out  2 each  registered control fields.
- ex_Jump, ex_Branch, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  1 each  registered control bits.
- ex_pc4, ex_rs_data, ex_rt_data  out  DATA_W  registered operands.
- ex_imm  out  DATA_W  extended immediate.
- ex_rs, ex_rt  out  REG_AW  registered specifiers, for forwarding.
- ex_wreg  out  REG_AW  resolved write-back register.
- bubble_cnt  out  32  count of inserted bubbles (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: every ex_* output is 0, ex_valid=0, bubble_cnt=0.
- Load-use hazard, combinational:
  - load_use = ex_valid & ex_MemRead & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | ((ex_rt == id_rt) & (~id_ALUSrc | id_MemWrite))).
  - id_rs is treated as always used.
- stall_out = (load_use & ~flush) | ex_hold.
- Per-edge update priority, highest first:
  1. reset: load reset values.
  2. flush: load a bubble (ex_valid=0, all control outputs 0); data outputs don't-care but driven to 0. flush overrides ex_hold and load_use.
  3. ex_hold: all ex_* registers keep their value.
  4. load_use: load a bubble. ID inputs are not consumed; the same ID instruction is re-presented next cycle, when load_use is false.
  5. otherwise: load from id_* with latency 1.
- id_valid=0 on a normal load: ex_valid=0 and all control outputs 0.
- Immediate extension: ex_imm = id_sign_or_zero ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm}.
- Write-back register (ex_wreg):
  - id_RegDst 2'b00 → id_rt.
  - 2'b01 → id_rd.
  - 2'b10 → 5'd31.
  - 2'b11 → 0, and ex_RegWrite is forced to 0.
- Writes to register 0: ex_RegWrite is forced to 0 whenever the resolved wreg is 0.
- Stall length: a load_use stall lasts exactly one cycle (the bubble clears ex_MemRead), unless ex_hold extends it.
- Reset mid-stall: stall_out falls the cycle after reset asserts, since ex_valid becomes 0.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined: bubble_cnt increments by 1 on every edge where a load_use bubble is loaded (not flush bubbles, not held cycles). It saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: bubble_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Reset held 2 cycles with random id_* inputs → all ex_* = 0, ex_valid=0, stall_out=0.
- R-type add $3,$1,$2 (RegDst=01, rd=3, valid) → next cycle ex_wreg=3, ex_RegWrite=1, ex_ALUOp=10, rs/rt data passed.
- lw $5,0($1) then add $6,$5,$2:
  - Cycle 2: stall_out=1.
  - Edge 2: ex_valid=0, ex_MemRead=0.
  - Cycle 3: stall_out=0, add loaded.
  - bubble_cnt=1 with the macro defined.
- lw $0,… then add using $0 → no stall.
- lw $5 then addi $7,$5,… (ALUSrc=1) → stall.
- lw $5 then addi $5,$1,… (rt match only) → no stall.
- addi with imm=16'h8000:
  - sign_or_zero=1 → ex_imm=32'hFFFF8000.
  - sign_or_zero=0 → ex_imm=32'h00008000.
- jal (RegDst=10, RegWrite=1): ex_wreg=31.
- flush asserted together with load_use and ex_hold → bubble loaded, bubble_cnt unchanged.
- ex_hold for 3 cycles → outputs frozen, stall_out=1 throughout.
